// File: rtl/ps_linebuffer.sv
// Purpose: single-line 8-bit pixel store that replays the line as 3-tap {left, centre, right} windows.
// Latency: o_rdata holds the window for a read immediately after the rising edge that sampled i_rd.
// Backpressure: none; the writer must fill a line before it is read, and pointers wrap freely.
module ps_linebuffer #(
  parameter int LINE_LENGTH = 640
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_wr,
  input  logic [7:0]  i_wdata,
  input  logic        i_rd,
  output logic [23:0] o_rdata
);

  localparam int AW = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(LINE_LENGTH - 1);

  // A window needs distinct left, centre and right pixels, so shorter lines are meaningless.
  generate
    if (LINE_LENGTH < 3) begin : g_bad_len
      $error("ps_linebuffer: LINE_LENGTH must be >= 3");
    end
  endgenerate

  // Line storage; deliberately not reset, only the pointers define what is valid.
  logic [7:0] mem [LINE_LENGTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr_nxt;
  logic [AW-1:0] rptr_nxt;
  logic [AW-1:0] lptr;
  logic [7:0]    left;
  logic [7:0]    centre;
  logic [7:0]    right;

  // Wrapping pointer increments and neighbour addresses around the read pointer.
  always_comb begin
    wptr_nxt = (wptr == LAST) ? '0 : wptr + 1'b1;
    rptr_nxt = (rptr == LAST) ? '0 : rptr + 1'b1;
    lptr     = (rptr == '0) ? LAST : rptr - 1'b1;
  end

  // Window taps; the line ends are zero-padded instead of wrapping into the neighbouring line.
  always_comb begin
    left   = (rptr == '0)   ? 8'h00 : mem[lptr];
    centre = mem[rptr];
    right  = (rptr == LAST) ? 8'h00 : mem[rptr_nxt];
  end

  // Pixel write; a same-cycle read of this address sees the old value because o_rdata
  // samples the array before this update lands.
  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      mem[wptr] <= i_wdata;
    end
  end

  // Write pointer advances one pixel per accepted write.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wptr <= '0;
    end else if (i_wr) begin
      wptr <= wptr_nxt;
    end
  end

  // Read pointer and registered window; both hold while i_rd is low.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rptr    <= '0;
      o_rdata <= 24'h000000;
    end else if (i_rd) begin
      rptr    <= rptr_nxt;
      o_rdata <= {left, centre, right};
    end
  end

endmodule

// File: tb/tb_ps_linebuffer.sv
// Self-checking bench for ps_linebuffer: directed sequence with a queue of expected windows.
module tb_ps_linebuffer;

  localparam int L = 640;

  logic        i_clk;
  logic        i_rstn;
  logic        i_wr;
  logic [7:0]  i_wdata;
  logic        i_rd;
  logic [23:0] o_rdata;

  ps_linebuffer #(.LINE_LENGTH(L)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_wr    (i_wr),
    .i_wdata (i_wdata),
    .i_rd    (i_rd),
    .o_rdata (o_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference state kept by the bench.
  logic [7:0]  m [L];
  int          wp;
  int          rp;
  logic [23:0] held;
  logic [23:0] sb [$];

  logic [7:0] d [L];
  logic [7:0] e [L];
  logic [7:0] f [L];
  logic [7:0] b [L];

  int tests;
  int fails;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus driven at a falling edge; output checked at the next falling edge.
  task automatic step(input bit wr, input logic [7:0] wd, input bit rd, input string tag);
    logic [23:0] x;
    i_wr    = wr;
    i_wdata = wd;
    i_rd    = rd;
    if (rd) begin
      x = {(rp == 0) ? 8'h00 : m[rp-1], m[rp], (rp == L-1) ? 8'h00 : m[rp+1]};
      sb.push_back(x);
      rp = (rp == L-1) ? 0 : rp + 1;
    end
    if (wr) begin
      m[wp] = wd;
      wp = (wp == L-1) ? 0 : wp + 1;
    end
    @(negedge i_clk);
    if (rd) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, o_rdata);
      end else begin
        held = sb.pop_front();
      end
    end
    chk(tag, o_rdata, held);
    i_wr = 1'b0;
    i_rd = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    wp      = 0;
    rp      = 0;
    held    = 24'h000000;
    i_rstn  = 1'b0;
    i_wr    = 1'b0;
    i_wdata = 8'h00;
    i_rd    = 1'b0;
    for (int i = 0; i < L; i++) begin
      m[i] = 8'h00;
      d[i] = 8'($urandom_range(0, 255));
      e[i] = 8'($urandom_range(0, 255));
      f[i] = 8'($urandom_range(0, 255));
      b[i] = 8'($urandom_range(0, 255));
    end

    // Reset held for 100 ns, then idle cycles with no strobes.
    repeat (10) @(negedge i_clk);
    chk("reset_value", o_rdata, 24'h000000);
    i_rstn = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, "idle_after_reset");
    chk("idle_value", o_rdata, 24'h000000);

    // Fill line d, then read it with a pause after read 100.
    for (int i = 0; i < L; i++) step(1'b1, d[i], 1'b0, "write_d");
    for (int k = 1; k <= L; k++) begin
      step(1'b0, 8'h00, 1'b1, "read_d");
      if (k == 1)   chk("d_read1",   o_rdata, {8'h00, d[0], d[1]});
      if (k == 2)   chk("d_read2",   o_rdata, {d[0], d[1], d[2]});
      if (k == 101) chk("d_resume",  o_rdata, {d[99], d[100], d[101]});
      if (k == 639) chk("d_read639", o_rdata, {d[637], d[638], d[639]});
      if (k == L)   chk("d_read640", o_rdata, {d[638], d[639], 8'h00});
      if (k == 100) begin
        for (int h = 0; h < 5; h++) step(1'b0, 8'h00, 1'b0, "hold");
        chk("d_hold", o_rdata, {d[98], d[99], d[100]});
      end
    end

    // Read past the end wraps to pixel 0; finish that pass.
    step(1'b0, 8'h00, 1'b1, "wrap_read");
    chk("wrap_first", o_rdata, {8'h00, d[0], d[1]});
    for (int k = 1; k < L; k++) step(1'b0, 8'h00, 1'b1, "wrap_pass");

    // New line e overwrites, then 300 reads before a mid-line reset.
    for (int i = 0; i < L; i++) step(1'b1, e[i], 1'b0, "write_e");
    for (int k = 1; k <= 300; k++) begin
      step(1'b0, 8'h00, 1'b1, "read_e");
      if (k == 1) chk("e_read1", o_rdata, {8'h00, e[0], e[1]});
    end
    i_rstn = 1'b0;
    #1;
    chk("async_reset", o_rdata, 24'h000000);
    wp   = 0;
    rp   = 0;
    held = 24'h000000;
    @(negedge i_clk);
    chk("reset_hold", o_rdata, 24'h000000);
    i_rstn = 1'b1;

    // Line f after reset: write and read from pixel 0.
    for (int i = 0; i < L; i++) step(1'b1, f[i], 1'b0, "write_f");
    for (int k = 1; k <= L; k++) begin
      step(1'b0, 8'h00, 1'b1, "read_f");
      if (k == 1) chk("f_read1", o_rdata, {8'h00, f[0], f[1]});
      if (k == L) chk("f_read640", o_rdata, {f[638], f[639], 8'h00});
    end

    // Read line f while line b is written one address behind the reader.
    step(1'b0, 8'h00, 1'b1, "conc_read0");
    chk("conc_first", o_rdata, {8'h00, f[0], f[1]});
    for (int k = 1; k < L; k++) begin
      step(1'b1, b[k-1], 1'b1, "conc_rw");
      if (k == 1)   chk("conc_k1",   o_rdata, {f[0], f[1], f[2]});
      if (k == 320) chk("conc_k320", o_rdata, {f[319], f[320], f[321]});
      if (k == L-1) chk("conc_last", o_rdata, {f[638], f[639], 8'h00});
    end
    step(1'b1, b[L-1], 1'b0, "conc_tail");

    // Line b is now fully stored.
    for (int k = 1; k <= L; k++) begin
      step(1'b0, 8'h00, 1'b1, "read_b");
      if (k == 1)   chk("b_read1",   o_rdata, {8'h00, b[0], b[1]});
      if (k == 200) chk("b_read200", o_rdata, {b[198], b[199], b[200]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
